uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter for the FPGC IO subsystem and counterpart of the UART receiver. It serialises bytes as 8N1 frames: one start bit (0), eight data bits LSB first, one stop bit (1), no parity. Bytes enter through a one-cycle valid strobe gated by a ready flag. They are held in a buffer so that the CPU-side MMIO write does not stall for the length of a frame.

## Interface
Parameters:
- CLKS_PER_BIT, default 50, sets i_Clock cycles per bit (1 MBaud at 50 MHz). The legal range is 2..511, because the bit counter is 9 bits.
- FIFO_DEPTH, default 16, sets the number of buffer entries when UARTTX_FIFO_EN is defined. It must be a power of 2, at least 2.

Ports:
- i_Clock, in, 1: the single clock.
- reset_n, in, 1: synchronous, active-low reset. The design has one clock, and the reset is synchronous and active-low.
- i_Tx_DV, in, 1: write strobe. It is accepted only on a cycle where o_Tx_Ready=1.
- i_Tx_Byte, in, 8: the byte to send. It is sampled together with i_Tx_DV.
- o_Tx_Ready, out, 1: high when the buffer can accept a byte.
- o_Tx_Active, out, 1: high while a frame is on the line, from the START state through the STOP state.
- o_Tx_Serial, out, 1: the serial line. It idles high.
- o_Tx_Done, out, 1: a one-cycle pulse after each stop bit completes.

## Operation
- Reset (reset_n=0 sampled at an edge):
  - Outputs after that edge: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1.
  - The buffer is emptied, the state goes to IDLE, and the counters are cleared.
  - A frame in progress is abandoned and the line returns high immediately. No partial byte is resumed.
- Buffer behaviour:
  - Without the FIFO: a single holding register with a valid flag. o_Tx_Ready = !valid.
  - With the FIFO: o_Tx_Ready = !full. The read side is first-word-fall-through.
  - A write while o_Tx_Ready=0 is silently dropped, even if a pop happens in the same cycle. There is no write-through bypass.
- State machine (all outputs registered):
  - IDLE: line high. If the buffer is non-empty, pop the byte into the shift register and go to START. Otherwise stay in IDLE.
  - START: line 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line = shift[bit index] for CLKS_PER_BIT cycles. After bit 7, go to STOP. Otherwise increment the bit index.
  - STOP: line 1 for CLKS_PER_BIT cycles, then go to CLEANUP.
  - CLEANUP: line 1 and o_Tx_Done=1 for exactly one cycle, then go to IDLE.
  - An illegal state encoding goes to IDLE with the line high.
- Bit timing:
  - The bit counter counts 0..CLKS_PER_BIT-1. The bit ends when the count reaches CLKS_PER_BIT-1, and the counter then wraps to 0.
  - The bit index is 3 bits and is cleared in IDLE.
- i_Tx_Byte changing after acceptance has no effect on the frame.

## Timing
- Let T be the edge at which a write is accepted while the block is idle with an empty buffer.
  - The start bit (o_Tx_Serial=0) first appears after edge T+1. This latency is the same in both configurations.
  - The start bit occupies cycles T+1..T+C, where C=CLKS_PER_BIT.
  - Data bit k occupies cycles T+1+(k+1)C .. T+(k+2)C.
  - The stop bit ends at T+10C.
  - o_Tx_Done is high during cycle T+10C+1.
- Back-to-back frames from a non-empty buffer: start-bit falling edges are exactly 10C+2 cycles apart.
- o_Tx_Ready timing:
  - It drops the cycle after the write that fills the buffer.
  - In holding mode it rises the cycle after the IDLE pop.

## Configuration
- UARTTX_FIFO_EN:
  - When defined, the buffer is a FIFO_DEPTH-entry FIFO with full and empty flags. Wrap-around uses log2(FIFO_DEPTH)+1-bit pointers.
  - When undefined, the buffer is a one-entry holding register, the FIFO_DEPTH parameter is ignored, and no FIFO logic is synthesised.
- Serial timing is identical in both configurations.

## Structure
- Shared package uart_pkg contains:
  - The state encodings: S_IDLE=3'd0, S_START=3'd1, S_DATA=3'd2, S_STOP=3'd3, S_CLEANUP=3'd4. These are shared with the receiver.
  - The default CLKS_PER_BIT and the 9-bit counter width.
- There is one sub-module, uart_tx_fifo: a synchronous FWFT FIFO with ports wr_en, wr_data, rd_en, rd_data, full, empty, and the same clock and reset. It is instantiated only under UARTTX_FIFO_EN.

## Test plan
- Single byte, C=4: write 0xA5 at T. o_Tx_Serial reads 0,1,0,1,0,0,1,0,1,1, each value held for 4 cycles from T+1. o_Tx_Done pulses at T+41, and o_Tx_Active is high from T+1 to T+40.
- Back-to-back, C=4: write 0x00 then 0xFF on consecutive cycles, with the FIFO enabled. Start edges fall at T+1 and T+43, and the bench receiver decodes 0x00 then 0xFF.
- Overflow (FIFO, depth 4):
  - With the transmitter busy, write 6 bytes 0x10..0x15.
  - o_Tx_Ready goes low after the 4th buffered write, so 0x15 is dropped.
  - The line carries 0x10..0x14, which is the byte in flight plus the 4 buffered bytes.
- Holding mode: write 0x3C while idle, then write 0x77 while o_Tx_Ready=0. Only 0x3C is sent, and o_Tx_Ready returns to 1 at T+2.
- Reset mid-frame: assert reset_n=0 for 1 cycle during data bit 3 of 0x5A. After that edge, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Ready=1, and no o_Tx_Done pulse appears.
- Loopback: connect o_Tx_Serial to the UART receiver with C=50 and send 0x00..0xFF. The receiver's data-valid output fires 256 times, with matching bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings common to transmitter and receiver, default
// bit timing and the bit-counter width.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 50;
    localparam int unsigned CNT_W            = 9;
    localparam int unsigned STATE_W          = 3;
    localparam int unsigned DATA_W           = 8;

    typedef logic [DATA_W-1:0] uart_byte_t;

    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_START   = 3'd1;
    localparam logic [STATE_W-1:0] S_DATA    = 3'd2;
    localparam logic [STATE_W-1:0] S_STOP    = 3'd3;
    localparam logic [STATE_W-1:0] S_CLEANUP = 3'd4;

endpackage

// File: rtl/uart_tx_if.sv
// Byte write handshake between the CPU-side MMIO logic and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic       i_Tx_DV;
    uart_byte_t i_Tx_Byte;
    logic       o_Tx_Ready;

    modport master (output i_Tx_DV, output i_Tx_Byte, input  o_Tx_Ready);
    modport slave  (input  i_Tx_DV, input  i_Tx_Byte, output o_Tx_Ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO with wrap-bit pointers; used only when the
// transmitter is built with UARTTX_FIFO_EN.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  uart_byte_t wr_data,
    input  logic       rd_en,
    output uart_byte_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    uart_byte_t    mem_q [DEPTH];
    logic          do_wr;
    logic          do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register, or a FIFO_DEPTH-entry
// FWFT FIFO when UARTTX_FIFO_EN is defined.
module uart_tx import uart_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic     i_Clock,
    input  logic     reset_n,
    uart_tx_if.slave tx_if,
    output logic     o_Tx_Active,
    output logic     o_Tx_Serial,
    output logic     o_Tx_Done
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 511 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx: CLKS_PER_BIT must be 2..511 and FIFO_DEPTH a power of 2 >= 2");
    end

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         idx_next;
    uart_byte_t         shift_q, shift_d;
    logic               serial_q, serial_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               bit_end;
    logic               pop;
    logic               wr_en;
    logic               buf_full;
    logic               buf_empty;
    uart_byte_t         buf_data;

    // A write is taken only while ready is shown and the buffer truly has room.
    assign wr_en = tx_if.i_Tx_DV & ready_q & ~buf_full;

`ifdef UARTTX_FIFO_EN
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (i_Clock),
        .rst_n   (reset_n),
        .wr_en   (wr_en),
        .wr_data (tx_if.i_Tx_Byte),
        .rd_en   (pop),
        .rd_data (buf_data),
        .full    (buf_full),
        .empty   (buf_empty)
    );
`else
    logic       hold_valid_q, hold_valid_d;
    uart_byte_t hold_data_q, hold_data_d;

    assign buf_full  = hold_valid_q;
    assign buf_empty = ~hold_valid_q;
    assign buf_data  = hold_data_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (pop)   hold_valid_d = 1'b0;
        if (wr_en) begin
            hold_valid_d = 1'b1;
            hold_data_d  = tx_if.i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end
`endif

    assign bit_end  = (cnt_q == BIT_LAST);
    assign idx_next = idx_q + 3'd1;
    assign ready_d  = ~buf_full;

    // Serial, active and done are computed as next values so they leave on flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
                if (!buf_empty) begin
                    pop      = 1'b1;
                    shift_d  = buf_data;
                    state_d  = S_START;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d  = S_STOP;
                        serial_d = 1'b1;
                    end else begin
                        idx_d    = idx_next;
                        serial_d = shift_q[idx_next];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = S_CLEANUP;
                    serial_d = 1'b1;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLEANUP: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign tx_if.o_Tx_Ready = ready_q;
    assign o_Tx_Serial      = serial_q;
    assign o_Tx_Active      = active_q;
    assign o_Tx_Done        = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: frame vectors, back-to-back frames,
// buffer-full behaviour, mid-frame reset and a 256-byte loopback through a bench receiver.
module tb_uart_tx;

    localparam int C     = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 is transmitted first (start bit)
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic active;
    logic serial;
    logic done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int t_w      = 0;
    bit rx_en    = 1'b1;

    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    vec_t       vecs[5];

    uart_tx_if tx_if ();

    uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock     (clk),
        .reset_n     (rst_n),
        .tx_if       (tx_if),
        .o_Tx_Active (active),
        .o_Tx_Serial (serial),
        .o_Tx_Done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Bench receiver: samples each bit mid-cell, records start cycle and byte.
    initial begin : rx_proc
        int         s;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && serial === 1'b0) begin
                s = cyc;
                repeat (C + C / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    b[k] = serial;
                    repeat (C) @(negedge clk);
                end
                if (serial === 1'b1 && rx_en) begin
                    rx_q.push_back(b);
                    rx_start_q.push_back(s);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=event", nm);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_start_q.delete();
    endtask

    // Called at a negedge; returns at the negedge of cycle T with t_w = T.
    task automatic write_byte(input logic [7:0] d);
        tx_if.i_Tx_DV   = 1'b1;
        tx_if.i_Tx_Byte = d;
        @(negedge clk);
        t_w             = cyc;
        tx_if.i_Tx_DV   = 1'b0;
        tx_if.i_Tx_Byte = ~d;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        @(negedge clk);
        while (tx_if.o_Tx_Ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_timeout(nm);
    endtask

    task automatic wait_idle(input string nm);
        int quiet = 0;
        int n     = 0;
        while (quiet < 4 && n < 2000) begin
            @(negedge clk);
            n++;
            if (active === 1'b0 && tx_if.o_Tx_Ready === 1'b1) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) fail_timeout(nm);
    endtask

    task automatic wait_rx(input string nm, input int cnt, input int bound);
        int n = 0;
        while (rx_q.size() < cnt && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (rx_q.size() < cnt) fail_timeout(nm);
    endtask

    // One frame from idle: per-bit line check, active window, done pulse, decode.
    task automatic frame_check(input vec_t v);
        logic [C-1:0] w;
        bit           act_all   = 1'b1;
        bit           done_seen = 1'b0;
        string        nm;
        nm = $sformatf("frame_%02h", v.data);
        wait_idle({nm, "_idle"});
        clear_rx();
        write_byte(v.data);
        check({nm, "_t0_serial"}, 32'(serial), 32'd1);
        check({nm, "_t0_active"}, 32'(active), 32'd0);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < C; c++) begin
                @(negedge clk);
                w[c] = serial;
                if (active !== 1'b1) act_all = 1'b0;
                if (done !== 1'b0) done_seen = 1'b1;
            end
            check($sformatf("%s_bit%0d", nm, b), 32'(w), 32'({C{v.frame[b]}}));
        end
        check({nm, "_active_window"}, 32'(act_all), 32'd1);
        check({nm, "_done_early"}, 32'(done_seen), 32'd0);
        @(negedge clk);
        check({nm, "_done_pulse"}, 32'(done), 32'd1);
        check({nm, "_active_off"}, 32'(active), 32'd0);
        check({nm, "_stop_high"}, 32'(serial), 32'd1);
        @(negedge clk);
        check({nm, "_done_once"}, 32'(done), 32'd0);
        check({nm, "_rx_count"}, 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) begin
            check({nm, "_rx_data"}, 32'(rx_q[0]), 32'(v.data));
            check({nm, "_rx_start"}, 32'(rx_start_q[0]), 32'(t_w + 1));
        end
    endtask

    initial begin
        int t0;
        int d0;
        bit line_low;
        bit act_seen;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h5A, 10'b1010110100};
        vecs[4] = '{8'h81, 10'b1100000010};

        rst_n           = 1'b0;
        tx_if.i_Tx_DV   = 1'b0;
        tx_if.i_Tx_Byte = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_serial", 32'(serial), 32'd1);
        check("reset_active", 32'(active), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ready", 32'(tx_if.o_Tx_Ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) frame_check(vecs[i]);

        // Back-to-back frames: start edges 10C+2 cycles apart.
        wait_idle("b2b_idle");
        clear_rx();
`ifdef UARTTX_FIFO_EN
        tx_if.i_Tx_DV   = 1'b1;
        tx_if.i_Tx_Byte = 8'h00;
        @(negedge clk);
        t0              = cyc;
        tx_if.i_Tx_Byte = 8'hFF;
        @(negedge clk);
        tx_if.i_Tx_DV   = 1'b0;
`else
        write_byte(8'h00);
        t0 = t_w;
        wait_ready("b2b_ready");
        write_byte(8'hFF);
`endif
        wait_rx("b2b_rx", 2, 200);
        if (rx_q.size() >= 2) begin
            check("b2b_byte0", 32'(rx_q[0]), 32'h00);
            check("b2b_byte1", 32'(rx_q[1]), 32'hFF);
            check("b2b_start0", 32'(rx_start_q[0]), 32'(t0 + 1));
            check("b2b_start1", 32'(rx_start_q[1]), 32'(t0 + 43));
        end

`ifdef UARTTX_FIFO_EN
        // Overflow: one byte in flight, four buffered, the sixth dropped.
        wait_idle("ovf_idle");
        clear_rx();
        write_byte(8'h10);
        @(negedge clk);
        check("ovf_busy", 32'(active), 32'd1);
        tx_if.i_Tx_DV = 1'b1;
        for (int i = 1; i < 6; i++) begin
            tx_if.i_Tx_Byte = 8'(8'h10 + i);
            @(negedge clk);
        end
        tx_if.i_Tx_DV = 1'b0;
        check("ovf_ready_low", 32'(tx_if.o_Tx_Ready), 32'd0);
        wait_rx("ovf_rx", 5, 400);
        repeat (60) @(negedge clk);
        check("ovf_rx_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check($sformatf("ovf_byte%0d", i), 32'(rx_q[i]), 32'(8'h10 + i));
`else
        // Holding register: a write while not ready is discarded.
        wait_idle("hold_idle");
        clear_rx();
        write_byte(8'h3C);
        @(negedge clk);
        check("hold_ready_low", 32'(tx_if.o_Tx_Ready), 32'd0);
        tx_if.i_Tx_DV   = 1'b1;
        tx_if.i_Tx_Byte = 8'h77;
        @(negedge clk);
        tx_if.i_Tx_DV   = 1'b0;
        check("hold_ready_back", 32'(tx_if.o_Tx_Ready), 32'd1);
        repeat (100) @(negedge clk);
        check("hold_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("hold_rx_byte", 32'(rx_q[0]), 32'h3C);
`endif

        // Reset during data bit 3 of 0x5A abandons the frame.
        wait_idle("rst_idle");
        rx_en = 1'b0;
        write_byte(8'h5A);
        d0 = done_cnt;
        repeat (18) @(negedge clk);
        check("rst_pre_bit3", 32'(serial), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_serial", 32'(serial), 32'd1);
        check("rst_active", 32'(active), 32'd0);
        check("rst_ready", 32'(tx_if.o_Tx_Ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        line_low = 1'b0;
        act_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (serial !== 1'b1) line_low = 1'b1;
            if (active !== 1'b0) act_seen = 1'b1;
        end
        check("rst_line_quiet", 32'(line_low), 32'd0);
        check("rst_no_active", 32'(act_seen), 32'd0);
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        clear_rx();
        rx_en = 1'b1;

        // Loopback of every byte value.
        d0 = done_cnt;
        for (int b = 0; b < 256; b++) begin
            wait_ready("lb_ready");
            write_byte(8'(b));
        end
        wait_rx("lb_rx", 256, 2000);
        repeat (5) @(negedge clk);
        check("lb_rx_count", 32'(rx_q.size()), 32'd256);
        check("lb_done_count", 32'(done_cnt - d0), 32'd256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++)
            check($sformatf("lb_byte%0d", i), 32'(rx_q[i]), 32'(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
